reward_writeback: RTL

Write-side counterpart of the `reward` block. `reward` reads routing state from `mem` and produces an 80-bit reward record. `reward_writeback` takes that record, writes it back into `mem` as five 16-bit words, then reads the words back and checks them. It sits between `reward` (`done_reward` → `start`) and the `mem` write port, and signals the next stage with `done_update`.

---
 rtl/reward_writeback_pkg.sv | 32 +++
 rtl/reward_writeback_verify.sv | 64 ++++++
 rtl/reward_writeback.sv | 138 +++++++++++++
 3 files changed

// File: rtl/reward_writeback_pkg.sv
// Shared constants, FSM encoding and record word helper for reward_writeback.
// Pure definitions: no logic and no latency.
// No flow control of its own; users import these values.
package reward_writeback_pkg;

    localparam int WORD_WIDTH  = 16;   // memory word width
    localparam int REC_WORDS   = 5;    // words per reward record
    localparam int ADDR_STRIDE = 2;    // byte-address step per word
    localparam int REC_WIDTH   = 80;   // reward record width, shared with reward
    localparam int ADDR_WIDTH  = 16;
    localparam int IDX_WIDTH   = 3;

    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(REC_WORDS - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WRITE  = 2'd1,
        ST_VERIFY = 2'd2,
        ST_DONE   = 2'd3
    } wb_state_e;

    // Word k of a record; word 0 is the most significant 16 bits.
    function automatic logic [WORD_WIDTH-1:0] rec_word(
        input logic [REC_WIDTH-1:0] rec,
        input logic [IDX_WIDTH-1:0] k
    );
        logic [REC_WIDTH-1:0] sh;
        sh = rec << (WORD_WIDTH * int'(k));
        return sh[REC_WIDTH-1 -: WORD_WIDTH];
    endfunction

endpackage

// File: rtl/reward_writeback_verify.sv
// Registered read-back compare with first-error capture for reward_writeback.
// Latency: issue registered one edge, compared against read data the next edge.
// No backpressure; one compare per cycle while iss_vld is high.
//
// Ports: clock/reset; clr clears the error state on a new record;
// iss_vld/iss_idx/iss_exp issue a compare alongside the read address;
// rd_dat is registered memory read data; verify_err/err_index hold the result.
module wb_verify
    import reward_writeback_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  clr,
    input  logic                  iss_vld,
    input  logic [IDX_WIDTH-1:0]  iss_idx,
    input  logic [WORD_WIDTH-1:0] iss_exp,
    input  logic [WORD_WIDTH-1:0] rd_dat,
    output logic                  verify_err,
    output logic [IDX_WIDTH-1:0]  err_index
);

    logic                  stg_vld_q, stg_vld_d;
    logic [IDX_WIDTH-1:0]  stg_idx_q, stg_idx_d;
    logic [WORD_WIDTH-1:0] stg_exp_q, stg_exp_d;
    logic                  err_q, err_d;
    logic [IDX_WIDTH-1:0]  eidx_q, eidx_d;

    // The stage aligns the expected word with the memory's one-cycle read delay.
    always_comb begin
        stg_vld_d = iss_vld;
        stg_idx_d = iss_idx;
        stg_exp_d = iss_exp;
        err_d     = err_q;
        eidx_d    = eidx_q;
        if (clr) begin
            err_d  = 1'b0;
            eidx_d = '0;
        end else if (stg_vld_q && !err_q && (rd_dat != stg_exp_q)) begin
            // Only the first mismatch of a record is kept.
            err_d  = 1'b1;
            eidx_d = stg_idx_q;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            stg_vld_q <= 1'b0;
            stg_idx_q <= '0;
            stg_exp_q <= '0;
            err_q     <= 1'b0;
            eidx_q    <= '0;
        end else begin
            stg_vld_q <= stg_vld_d;
            stg_idx_q <= stg_idx_d;
            stg_exp_q <= stg_exp_d;
            err_q     <= err_d;
            eidx_q    <= eidx_d;
        end
    end

    assign verify_err = err_q;
    assign err_index  = eidx_q;

endmodule

// File: rtl/reward_writeback.sv
// Writes an 80-bit reward record to mem as five words, reads them back and checks.
// Latency: 11 edges from accepting start to the done_update pulse.
// No queueing: start is ignored until the FSM is back in IDLE.
//
// Ports: clock/reset (sync, active high); start/reward_data_in/base_addr accept a
// record; address/wr_en/mem_data_in drive the mem port, mem_data_out is its
// registered read data; busy/done_update/verify_err/err_index report status.
module reward_writeback
    import reward_writeback_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [REC_WIDTH-1:0]  reward_data_in,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    output logic [ADDR_WIDTH-1:0] address,
    output logic                  wr_en,
    output logic [WORD_WIDTH-1:0] mem_data_in,
    input  logic [WORD_WIDTH-1:0] mem_data_out,
    output logic                  busy,
    output logic                  done_update,
    output logic                  verify_err,
    output logic [IDX_WIDTH-1:0]  err_index
);

    wb_state_e             state_q, state_d;
    logic [IDX_WIDTH-1:0]  cnt_q, cnt_d;
    logic [REC_WIDTH-1:0]  rec_q, rec_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [ADDR_WIDTH-1:0] address_q, address_d;
    logic                  wr_en_q, wr_en_d;
    logic [WORD_WIDTH-1:0] wdat_q, wdat_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  accept;

    assign accept = (state_q == ST_IDLE) && start;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rec_d     = rec_q;
        base_d    = base_q;
        address_d = address_q;
        wr_en_d   = 1'b0;
        wdat_d    = wdat_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    // Word 0 goes out straight from the inputs so the first
                    // write commits on the edge after the accept.
                    rec_d     = reward_data_in;
                    base_d    = base_addr & ~ADDR_WIDTH'(1);
                    cnt_d     = '0;
                    address_d = base_addr & ~ADDR_WIDTH'(1);
                    wr_en_d   = 1'b1;
                    wdat_d    = rec_word(reward_data_in, '0);
                    busy_d    = 1'b1;
                    state_d   = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (cnt_q == LAST_IDX) begin
                    cnt_d     = '0;
                    address_d = base_q;
                    state_d   = ST_VERIFY;
                end else begin
                    cnt_d     = cnt_q + 1'b1;
                    address_d = address_q + ADDR_WIDTH'(ADDR_STRIDE);
                    wr_en_d   = 1'b1;
                    wdat_d    = rec_word(rec_q, cnt_q + 1'b1);
                end
            end
            ST_VERIFY: begin
                if (cnt_q == LAST_IDX) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d     = cnt_q + 1'b1;
                    address_d = address_q + ADDR_WIDTH'(ADDR_STRIDE);
                end
            end
            ST_DONE: begin
                // The last compare lands on this edge, so the pulse and the
                // final verify result appear together.
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            rec_q     <= '0;
            base_q    <= '0;
            address_q <= '0;
            wr_en_q   <= 1'b0;
            wdat_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rec_q     <= rec_d;
            base_q    <= base_d;
            address_q <= address_d;
            wr_en_q   <= wr_en_d;
            wdat_q    <= wdat_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // A compare is issued in the same cycle its read address is on the bus.
    wb_verify u_verify (
        .clock      (clock),
        .reset      (reset),
        .clr        (accept),
        .iss_vld    (state_q == ST_VERIFY),
        .iss_idx    (cnt_q),
        .iss_exp    (rec_word(rec_q, cnt_q)),
        .rd_dat     (mem_data_out),
        .verify_err (verify_err),
        .err_index  (err_index)
    );

    assign address     = address_q;
    assign wr_en       = wr_en_q;
    assign mem_data_in = wdat_q;
    assign busy        = busy_q;
    assign done_update = done_q;

endmodule
